// File: rtl/simplecpu_wb_loader_pkg.sv
// Shared constants for the simplecpu Wishbone program loader: register map,
// CTRL/STATUS bit positions and the drain state encoding.
package simplecpu_loader_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_OUT    = 3'd3;
    localparam logic [2:0] REG_CKSUM  = 3'd4;

    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    localparam int unsigned STAT_EMPTY    = 8;
    localparam int unsigned STAT_FULL     = 9;
    localparam int unsigned STAT_BUSY     = 10;
    localparam int unsigned STAT_OVF      = 11;
    localparam int unsigned STAT_DONE_LSB = 16;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_PULSE,
        DRAIN_GAP
    } drain_state_e;

endpackage

// File: rtl/simplecpu_wb_loader_if.sv
// Wishbone slave bus bundle for the simplecpu program loader.
interface simplecpu_wb_loader_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/simplecpu_wb_loader_fifo.sv
// Synchronous FIFO buffering {addr,data} program-RAM writes. Clear has priority;
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module loader_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/simplecpu_wb_loader.sv
// Wishbone loader for simplecpu: buffers LOAD writes and drains them as timed load_ram pulses,
// drives cpu_reset and samples out_port. Define LOADER_CHECKSUM_EN to add the CKSUM register.
module simplecpu_wb_loader
    import simplecpu_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOAD_PULSE = 2,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    simplecpu_wb_loader_if.slave  wb,
    output logic                  load_ram,
    output logic [ADDR_W-1:0]     load_addr,
    output logic [DATA_W-1:0]     load_data,
    output logic                  cpu_reset,
    input  logic [7:0]            out_port
);

    localparam int unsigned EW = ADDR_W + DATA_W;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (LOAD_PULSE > 1) ? $clog2(LOAD_PULSE) : 1;

    logic          sel;
    logic          req_we;
    logic [2:0]    req_off;
    logic [31:0]   req_dat;
    logic [31:0]   rd_val;
    logic          wr_commit;
    logic          ctrl_wr;
    logic          load_wr;
    logic          status_wr;
    logic          fifo_clear;

    logic          run;
    logic          overflow;
    logic [7:0]    out_q;
    logic [15:0]   loads_done;
    drain_state_e  state;
    logic [PW-1:0] pulse_cnt;
    logic          pulse_done;
    logic          start;
    logic          busy;
    logic [7:0]    cksum_rd;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_dout;

    logic          unused_bits;
    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], req_dat};

    assign sel = wb.wbs_stb_i && wb.wbs_cyc_i && !wb.wbs_ack_o
              && (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);

    // Writes are latched on selection and take effect in the ack cycle.
    assign wr_commit  = wb.wbs_ack_o && req_we;
    assign ctrl_wr    = wr_commit && (req_off == REG_CTRL);
    assign load_wr    = wr_commit && (req_off == REG_LOAD);
    assign status_wr  = wr_commit && (req_off == REG_STATUS);
    assign fifo_clear = ctrl_wr && req_dat[CTRL_CLEAR];

    assign busy       = (state != DRAIN_IDLE);
    assign pulse_done = (state == DRAIN_PULSE) && (pulse_cnt == '0);
    assign start      = (state != DRAIN_PULSE) && !fifo_empty && !run && !fifo_clear;

    always_comb begin
        rd_val = '0;
        case (wb.wbs_adr_i[4:2])
            REG_CTRL:   rd_val[CTRL_RUN] = run;
            REG_STATUS: begin
                rd_val[7:0]        = 8'(fifo_count);
                rd_val[STAT_EMPTY] = fifo_empty;
                rd_val[STAT_FULL]  = fifo_full;
                rd_val[STAT_BUSY]  = busy;
                rd_val[STAT_OVF]   = overflow;
                rd_val[31:STAT_DONE_LSB] = loads_done;
            end
            REG_OUT:    rd_val[7:0] = out_q;
            REG_CKSUM:  rd_val[7:0] = cksum_rd;
            default:    ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            req_we       <= 1'b0;
            req_off      <= '0;
            req_dat      <= '0;
        end else begin
            wb.wbs_ack_o <= sel;
            if (sel) begin
                req_we       <= wb.wbs_we_i;
                req_off      <= wb.wbs_adr_i[4:2];
                req_dat      <= wb.wbs_dat_i;
                wb.wbs_dat_o <= wb.wbs_we_i ? '0 : rd_val;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            run       <= 1'b0;
            overflow  <= 1'b0;
            cpu_reset <= 1'b1;
            out_q     <= '0;
        end else begin
            cpu_reset <= ~run;
            out_q     <= out_port;
            if (ctrl_wr) run <= req_dat[CTRL_RUN];
            if (status_wr && req_dat[STAT_OVF]) overflow <= 1'b0;
            else if (load_wr && fifo_full && !start) overflow <= 1'b1;
        end
    end

    loader_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .clear (fifo_clear),
        .push  (load_wr),
        .pop   (start),
        .din   (req_dat[EW-1:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // GAP also serves as the idle decision cycle, so queued entries are separated by one low cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= DRAIN_IDLE;
            load_ram   <= 1'b0;
            load_addr  <= '0;
            load_data  <= '0;
            pulse_cnt  <= '0;
            loads_done <= '0;
        end else begin
            case (state)
                DRAIN_PULSE: begin
                    if (pulse_done) begin
                        state      <= DRAIN_GAP;
                        load_ram   <= 1'b0;
                        loads_done <= loads_done + 16'd1;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= DRAIN_PULSE;
                        load_ram  <= 1'b1;
                        load_addr <= fifo_dout[EW-1:DATA_W];
                        load_data <= fifo_dout[DATA_W-1:0];
                        pulse_cnt <= PW'(LOAD_PULSE - 1);
                    end else begin
                        state <= DRAIN_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic       cksum_wr;
    logic [7:0] cksum;

    assign cksum_wr = wr_commit && (req_off == REG_CKSUM);
    assign cksum_rd = cksum;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cksum <= '0;
        end else if (fifo_clear || cksum_wr) begin
            cksum <= '0;
        end else if (pulse_done) begin
            cksum <= cksum + 8'(load_data);
        end
    end
`else
    assign cksum_rd = '0;
`endif

endmodule

// File: tb/tb_simplecpu_wb_loader.sv
// Self-checking bench for simplecpu_wb_loader: randomized loads checked against a queue model.
module tb_simplecpu_wb_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PULSE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_ram;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       cpu_reset;
    logic [7:0] out_port = 8'h00;

    simplecpu_wb_loader_if wb();

    simplecpu_wb_loader #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .LOAD_PULSE (PULSE),
        .ADDR_W     (4),
        .DATA_W     (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (wb.slave),
        .load_ram  (load_ram),
        .load_addr (load_addr),
        .load_data (load_data),
        .cpu_reset (cpu_reset),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        int unsigned len;
        int unsigned gap;
        bit          stable;
    } pulse_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } ent_t;

    pulse_t      obs[$];
    pulse_t      cur;
    bit          in_pulse = 0;
    int unsigned low_run  = 0;

    ent_t        exp_q[$];
    int unsigned m_done = 0;
    bit          m_ovf  = 0;
    bit          m_run  = 0;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    // Pulse monitor: records each load_ram pulse with its length, preceding low time and stability.
    always @(negedge clk) begin
        if (load_ram === 1'b1) begin
            if (!in_pulse) begin
                cur.addr = load_addr; cur.data = load_data;
                cur.len = 1; cur.gap = low_run; cur.stable = 1; in_pulse = 1;
            end else begin
                cur.len++;
                if (load_addr !== cur.addr || load_data !== cur.data) cur.stable = 0;
            end
        end else begin
            if (in_pulse) begin
                if (!rst && (load_addr !== cur.addr || load_data !== cur.data)) cur.stable = 0;
                obs.push_back(cur);
                in_pulse = 0;
                low_run  = 0;
            end
            low_run++;
        end
    end

    function automatic logic [31:0] exp_status(input int unsigned cnt, input bit busy,
                                               input bit ovf, input int unsigned done);
        logic [31:0] r;
        r = '0;
        r[7:0]   = cnt[7:0];
        r[8]     = (cnt == 0);
        r[9]     = (cnt == DEPTH);
        r[10]    = busy;
        r[11]    = ovf;
        r[31:16] = done[15:0];
        return r;
    endfunction

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        bit acked = 0;
        wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = 1;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = addr; wb.wbs_dat_i = data;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o === 1'b1) begin acked = 1; break; end
        end
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
        if (!acked) begin
            total_cnt++;
            $display("FAIL wb_write_ack addr=%h: no ack within 8 cycles, ack required", addr);
        end
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output bit acked);
        acked = 0; data = '0;
        wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = 0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = addr;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o === 1'b1) begin acked = 1; data = wb.wbs_dat_o; break; end
        end
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0;
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        wb_write(BASE, v);
        m_run = v[0];
    endtask

    task automatic do_load(input logic [3:0] a, input logic [7:0] d);
        logic [31:0] w;
        ent_t e;
        w = $urandom;
        w[11:0] = {a, d};
        wb_write(BASE + 32'h4, w);
        e.addr = a; e.data = d;
        if (m_run && exp_q.size() >= DEPTH) m_ovf = 1;
        else exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int unsigned n);
        for (int i = 0; i < 300 && obs.size() < n; i++) @(negedge clk);
        if (obs.size() < n) begin
            total_cnt++;
            $display("FAIL drain_timeout: saw %0d pulses, required %0d", obs.size(), n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_load_high();
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load_ram === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL load_ram_rise: load_ram stayed 0 for 30 cycles, 1 required");
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit ack;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got %b need 1", cpu_reset); else pass_cnt++;
        total_cnt++; if (load_ram !== 1'b0) $display("FAIL rst_load_ram got %b need 0", load_ram); else pass_cnt++;
        total_cnt++; if (load_addr !== 4'h0) $display("FAIL rst_load_addr got %h need 0", load_addr); else pass_cnt++;
        total_cnt++; if (load_data !== 8'h00) $display("FAIL rst_load_data got %h need 0", load_data); else pass_cnt++;
        total_cnt++; if (wb.wbs_ack_o !== 1'b0) $display("FAIL rst_ack got %b need 0", wb.wbs_ack_o); else pass_cnt++;
        total_cnt++; if (wb.wbs_dat_o !== 32'h0) $display("FAIL rst_dat got %h need 0", wb.wbs_dat_o); else pass_cnt++;
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (ack !== 1'b1) $display("FAIL rst_status_ack got %b need 1", ack); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0000_0100) $display("FAIL rst_status got %h need 00000100", rd); else pass_cnt++;
        m_done = 0; m_run = 0; m_ovf = 0;
    endtask

    task automatic test_single_load();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        wb_write(BASE + 32'h4, 32'h0000_03A5);
        wait_drain(1);
        total_cnt++; if (obs.size() != 1) $display("FAIL single_count got %0d need 1", obs.size()); else pass_cnt++;
        if (obs.size() >= 1) begin
            total_cnt++; if (obs[0].addr !== 4'h3) $display("FAIL single_addr got %h need 3", obs[0].addr); else pass_cnt++;
            total_cnt++; if (obs[0].data !== 8'hA5) $display("FAIL single_data got %h need a5", obs[0].data); else pass_cnt++;
            total_cnt++; if (obs[0].len != PULSE) $display("FAIL single_len got %0d need %0d", obs[0].len, PULSE); else pass_cnt++;
        end
        m_done = 1;
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(0, 0, 0, m_done)) $display("FAIL single_status got %h need %h", rd, exp_status(0, 0, 0, m_done)); else pass_cnt++;
        obs.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        set_ctrl(32'h1);
        repeat (2) @(negedge clk);
        total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL ovf_cpu_reset got %b need 0", cpu_reset); else pass_cnt++;
        for (int k = 0; k < 5; k++) do_load(4'($urandom), 8'($urandom));
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(exp_q.size(), 0, m_ovf, m_done)) $display("FAIL ovf_status got %h need %h", rd, exp_status(exp_q.size(), 0, m_ovf, m_done)); else pass_cnt++;
        wb_write(BASE + 32'h8, 32'h0000_0800);
        m_ovf = 0;
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(exp_q.size(), 0, 0, m_done)) $display("FAIL ovf_clear got %h need %h", rd, exp_status(exp_q.size(), 0, 0, m_done)); else pass_cnt++;
        set_ctrl(32'h0);
        wait_drain(exp_q.size());
        total_cnt++; if (obs.size() != exp_q.size()) $display("FAIL ovf_pulses got %0d need %0d", obs.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].len != PULSE
                || !obs[i].stable || (i > 0 && obs[i].gap != 1))
                $display("FAIL ovf_pulse%0d got a=%h d=%h len=%0d gap=%0d st=%0d need a=%h d=%h len=%0d gap=1 st=1",
                         i, obs[i].addr, obs[i].data, obs[i].len, obs[i].gap, obs[i].stable,
                         exp_q[i].addr, exp_q[i].data, PULSE);
            else pass_cnt++;
        end
        total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL ovf_cpu_reset_back got %b need 1", cpu_reset); else pass_cnt++;
        m_done += exp_q.size();
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(0, 0, 0, m_done)) $display("FAIL ovf_final got %h need %h", rd, exp_status(0, 0, 0, m_done)); else pass_cnt++;
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_run_midpulse();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        set_ctrl(32'h1);
        for (int k = 0; k < 3; k++) do_load(4'($urandom), 8'($urandom));
        set_ctrl(32'h0);
        wait_load_high();
        set_ctrl(32'h1);
        repeat (15) @(negedge clk);
        total_cnt++; if (obs.size() != 1) $display("FAIL mid_held_pulses got %0d need 1", obs.size()); else pass_cnt++;
        if (obs.size() >= 1) begin
            total_cnt++;
            if (obs[0].len != PULSE || obs[0].addr !== exp_q[0].addr || obs[0].data !== exp_q[0].data)
                $display("FAIL mid_first got len=%0d a=%h d=%h need len=%0d a=%h d=%h", obs[0].len, obs[0].addr, obs[0].data, PULSE, exp_q[0].addr, exp_q[0].data);
            else pass_cnt++;
        end
        total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL mid_cpu_reset got %b need 0", cpu_reset); else pass_cnt++;
        m_done += 1;
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(2, 0, 0, m_done)) $display("FAIL mid_status got %h need %h", rd, exp_status(2, 0, 0, m_done)); else pass_cnt++;
        set_ctrl(32'h0);
        wait_drain(3);
        total_cnt++; if (obs.size() != 3) $display("FAIL mid_resume_pulses got %0d need 3", obs.size()); else pass_cnt++;
        for (int i = 1; i < obs.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].len != PULSE)
                $display("FAIL mid_resume%0d got a=%h d=%h len=%0d need a=%h d=%h len=%0d", i, obs[i].addr, obs[i].data, obs[i].len, exp_q[i].addr, exp_q[i].data, PULSE);
            else pass_cnt++;
        end
        m_done += 2;
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) do_load(4'($urandom), 8'($urandom));
        wait_drain(4);
        total_cnt++; if (obs.size() != 4) $display("FAIL b2b_pulses got %0d need 4", obs.size()); else pass_cnt++;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].len != PULSE || !obs[i].stable || obs[i].gap < 1)
                $display("FAIL b2b_pulse%0d got a=%h d=%h len=%0d gap=%0d need a=%h d=%h len=%0d gap>=1", i, obs[i].addr, obs[i].data, obs[i].len, obs[i].gap, exp_q[i].addr, exp_q[i].data, PULSE);
            else pass_cnt++;
        end
        m_done += 4;
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(0, 0, 0, m_done)) $display("FAIL b2b_status got %h need %h", rd, exp_status(0, 0, 0, m_done)); else pass_cnt++;
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_fifo_clear();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        set_ctrl(32'h1);
        for (int k = 0; k < 3; k++) do_load(4'($urandom), 8'($urandom));
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(3, 0, 0, m_done)) $display("FAIL clr_before got %h need %h", rd, exp_status(3, 0, 0, m_done)); else pass_cnt++;
        set_ctrl(32'h3);
        exp_q.delete();
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== exp_status(0, 0, 0, m_done)) $display("FAIL clr_after got %h need %h", rd, exp_status(0, 0, 0, m_done)); else pass_cnt++;
        wb_read(BASE, rd, ack);
        total_cnt++; if (rd !== 32'h1) $display("FAIL clr_ctrl_read got %h need 00000001", rd); else pass_cnt++;
        set_ctrl(32'h0);
        repeat (20) @(negedge clk);
        total_cnt++; if (obs.size() != 0) $display("FAIL clr_no_pulses got %0d need 0", obs.size()); else pass_cnt++;
        obs.delete();
    endtask

    task automatic test_readback();
        logic [31:0] rd; bit ack;
        logic [7:0] v;
        out_port = 8'h5C;
        repeat (3) @(negedge clk);
        wb_read(BASE + 32'hC, rd, ack);
        total_cnt++; if (rd !== 32'h0000_005C) $display("FAIL out_5c got %h need 0000005c", rd); else pass_cnt++;
        v = 8'($urandom);
        out_port = v;
        repeat (3) @(negedge clk);
        wb_read(BASE + 32'hC, rd, ack);
        total_cnt++; if (rd !== {24'h0, v}) $display("FAIL out_rand got %h need %h", rd, {24'h0, v}); else pass_cnt++;
        wb_read(BASE + 32'h14, rd, ack);
        total_cnt++; if (ack !== 1'b1 || rd !== 32'h0) $display("FAIL off14 got ack=%b data=%h need ack=1 data=0", ack, rd); else pass_cnt++;
        wb_read(BASE + 32'h20, rd, ack);
        total_cnt++; if (ack !== 1'b0) $display("FAIL outside_20 got ack=%b need 0", ack); else pass_cnt++;
        wb_read(32'h2000_000C, rd, ack);
        total_cnt++; if (ack !== 1'b0) $display("FAIL outside_low got ack=%b need 0", ack); else pass_cnt++;
    endtask

    task automatic test_checksum();
        logic [31:0] rd; bit ack;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] sum;
        obs.delete(); exp_q.delete();
        set_ctrl(32'h2);
        do_load(4'($urandom), 8'hFF);
        wait_drain(1);
        do_load(4'($urandom), 8'h02);
        wait_drain(2);
        wb_read(BASE + 32'h10, rd, ack);
        total_cnt++; if (rd !== 32'h1) $display("FAIL cksum_ff02 got %h need 00000001", rd); else pass_cnt++;
        do_load(4'($urandom), 8'($urandom));
        wait_drain(3);
        sum = 8'h00;
        foreach (exp_q[i]) sum = sum + exp_q[i].data;
        wb_read(BASE + 32'h10, rd, ack);
        total_cnt++; if (rd !== {24'h0, sum}) $display("FAIL cksum_sum got %h need %h", rd, {24'h0, sum}); else pass_cnt++;
        m_done += 3;
        set_ctrl(32'h2);
        wb_read(BASE + 32'h10, rd, ack);
        total_cnt++; if (rd !== 32'h0) $display("FAIL cksum_clear got %h need 0", rd); else pass_cnt++;
        obs.delete(); exp_q.delete();
        do_load(4'($urandom), 8'h40);
        wait_drain(1);
        wb_write(BASE + 32'h10, 32'h0);
        wb_read(BASE + 32'h10, rd, ack);
        total_cnt++; if (rd !== 32'h0) $display("FAIL cksum_wr_clear got %h need 0", rd); else pass_cnt++;
        m_done += 1;
        obs.delete(); exp_q.delete();
`else
        wb_read(BASE + 32'h10, rd, ack);
        total_cnt++; if (ack !== 1'b1 || rd !== 32'h0) $display("FAIL cksum_absent got ack=%b data=%h need ack=1 data=0", ack, rd); else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd; bit ack;
        int unsigned n;
        for (int it = 0; it < 6; it++) begin
            obs.delete(); exp_q.delete();
            set_ctrl(32'h1);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) do_load(4'($urandom), 8'($urandom));
            wb_read(BASE + 32'h8, rd, ack);
            total_cnt++; if (rd !== exp_status(exp_q.size(), 0, m_ovf, m_done)) $display("FAIL rnd%0d_status got %h need %h", it, rd, exp_status(exp_q.size(), 0, m_ovf, m_done)); else pass_cnt++;
            if (m_ovf) begin wb_write(BASE + 32'h8, 32'h800); m_ovf = 0; end
            set_ctrl(32'h0);
            wait_drain(exp_q.size());
            total_cnt++; if (obs.size() != exp_q.size()) $display("FAIL rnd%0d_pulses got %0d need %0d", it, obs.size(), exp_q.size()); else pass_cnt++;
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                total_cnt++;
                if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].len != PULSE
                    || !obs[i].stable || (i > 0 && obs[i].gap != 1))
                    $display("FAIL rnd%0d_pulse%0d got a=%h d=%h len=%0d gap=%0d need a=%h d=%h len=%0d",
                             it, i, obs[i].addr, obs[i].data, obs[i].len, obs[i].gap, exp_q[i].addr, exp_q[i].data, PULSE);
                else pass_cnt++;
            end
            m_done += exp_q.size();
            wb_read(BASE + 32'h8, rd, ack);
            total_cnt++; if (rd !== exp_status(0, 0, 0, m_done)) $display("FAIL rnd%0d_final got %h need %h", it, rd, exp_status(0, 0, 0, m_done)); else pass_cnt++;
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; bit ack;
        obs.delete(); exp_q.delete();
        set_ctrl(32'h1);
        for (int k = 0; k < 3; k++) do_load(4'($urandom), 8'($urandom));
        set_ctrl(32'h0);
        wait_load_high();
        #2 rst = 1;
        #1;
        total_cnt++; if (load_ram !== 1'b0) $display("FAIL arst_load_ram got %b need 0", load_ram); else pass_cnt++;
        total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL arst_cpu_reset got %b need 1", cpu_reset); else pass_cnt++;
        @(negedge clk);
        rst = 0;
        m_done = 0; m_run = 0; m_ovf = 0;
        @(negedge clk);
        obs.delete(); exp_q.delete();
        wb_read(BASE + 32'h8, rd, ack);
        total_cnt++; if (rd !== 32'h0000_0100) $display("FAIL arst_status got %h need 00000100", rd); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++; if (obs.size() != 0) $display("FAIL arst_no_pulses got %0d need 0", obs.size()); else pass_cnt++;
    endtask

    initial begin
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
        wb.wbs_sel_i = '0; wb.wbs_dat_i = '0; wb.wbs_adr_i = '0;
        test_reset();
        test_single_load();
        test_overflow();
        test_run_midpulse();
        test_back_to_back();
        test_fifo_clear();
        test_readback();
        test_checksum();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
